cordic_line_issue: RTL and testbench
====================================

CORDIC_LINE_ISSUE -- requirements
Module: cordic_line_issue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning operand FIFO depth in entries (power of 2, 2..16).
REQ-002 SHALL have parameter MAX_INFLIGHT, default 16, meaning the maximum number of issued but uncompleted operations (1..31).
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; it is asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1, meaning the upstream operand is valid.
REQ-006 SHALL have port in_ready, output, 1, meaning an entry is accepted when in_valid and in_ready are both high at a clk edge.
REQ-007 SHALL have port in_mode, input, 1, selecting the operation: 0 = divide, 1 = multiply.
REQ-008 SHALL have port in_x, input, 16, the Q15 signed operand routed to the core input a.
REQ-009 SHALL have port in_y, input, 16, the Q15 signed operand routed to b (divide) or c (multiply).
REQ-010 SHALL have ports en, a, b, c, outputs, widths 1/16/16/16, which drive the linear-mode CORDIC core inputs.
REQ-011 SHALL have port done, input, 1, the core completion strobe; each high cycle completes one operation.
REQ-012 SHALL have port inflight, output, 5, holding the count of issued but uncompleted operations.
REQ-013 SHALL have port busy, output, 1, high when the FIFO is non-empty or inflight != 0.
REQ-014 SHALL have port range_err, output, 1, a one-cycle pulse when an entry is dropped by the range check.

Function
REQ-015 SHALL buffer {in_mode, in_x, in_y} in a FIFO of DEPTH entries; in_ready = !full (combinational from state only).
REQ-016 SHALL issue the FIFO head when the FIFO is non-empty and inflight < MAX_INFLIGHT; issue pops the head.
REQ-017 SHALL register the issue outputs: en=1 for exactly one cycle per issued entry, a=in_x; divide: b=in_y, c=0; multiply: b=0, c=in_y.
REQ-018 SHALL drive en=0 in non-issue cycles, with a/b/c holding their last values.
REQ-019 SHALL have a latency of one cycle: an entry accepted at edge N into an empty FIFO with no throttle drives en high after edge N+1.
REQ-020 SHALL sustain a throughput of one issue per cycle; a push and a pop in the same cycle both take effect and leave occupancy unchanged.
REQ-021 SHALL update inflight as +1 on issue and -1 on done; issue and done in the same cycle leave it unchanged.
REQ-022 SHALL ignore done while inflight==0 (no underflow).
REQ-023 SHALL stall issue while inflight == MAX_INFLIGHT and resume in the cycle after done lowers the count.
REQ-024 SHALL wrap the FIFO pointers modulo DEPTH; full and empty are distinguished by an extra pointer bit.

Reset
REQ-025 SHALL, while rst_n is low, asynchronously clear: FIFO empty, en=0, a=b=c=0, inflight=0, range_err=0, busy=0, in_ready=1.
REQ-026 SHALL, on reset mid-operation, discard queued entries and the in-flight count; done pulses after release are ignored per REQ-022.
REQ-027 SHALL deassert reset so that the first accept is possible on the first clk edge after rst_n goes high.

Configuration
REQ-028 SHALL, with macro CORDIC_RANGE_CHECK_EN defined, drop a divide head entry whose |in_y| >= |in_x| (17-bit magnitudes, so -32768 gives 32768): the entry is popped, en stays 0, range_err pulses for one cycle, and inflight is unchanged.
REQ-029 SHALL, without CORDIC_RANGE_CHECK_EN, issue all entries unconditionally and tie range_err to 0.

Verification
REQ-030 SHALL cover a single divide: push mode0 x=26213 y=19660 -> after one cycle en=1, a=26213, b=19660, c=0, inflight=1; done -> inflight=0, busy=0.
REQ-031 SHALL cover a burst: 4 back-to-back multiplies (x=26213, y=19660/3276/10485/6553) -> four consecutive en cycles in order, with b=0 and c=y each cycle.
REQ-032 SHALL cover throttling: MAX_INFLIGHT=2, 4 pushes with no done -> 2 issues, in_ready stays high until 2 entries queue; one done -> exactly one more issue the next cycle.
REQ-033 SHALL cover the full FIFO: 6 pushes with issue stalled -> in_ready=0 after 4 accepts, 2 entries held upstream, and no overwrite.
REQ-034 SHALL cover the range check with CORDIC_RANGE_CHECK_EN: divide x=16384 y=19660 -> range_err one-cycle pulse, no en; the following divide x=26213 y=8192 issues normally.
REQ-035 SHALL cover reset mid-burst: rst_n low with 3 queued and 2 in flight -> all outputs at reset values immediately, and a later done leaves inflight=0.

Source files
------------

// File: rtl/cordic_line_issue.sv
// Operand FIFO and issue stage feeding a linear-mode CORDIC core (divide/multiply).
// Ports: clk, rst_n, in_valid/in_ready/in_mode/in_x/in_y in; en/a/b/c core drive;
// done completion strobe; inflight count, busy, range_err.
// Optional divide range check enabled by macro CORDIC_RANGE_CHECK_EN.
module cordic_line_issue #(
  parameter int DEPTH        = 4,
  parameter int MAX_INFLIGHT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_mode,
  input  logic [15:0] in_x,
  input  logic [15:0] in_y,
  output logic        en,
  output logic [15:0] a,
  output logic [15:0] b,
  output logic [15:0] c,
  input  logic        done,
  output logic [4:0]  inflight,
  output logic        busy,
  output logic        range_err
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic        mode;
    logic [15:0] x;
    logic [15:0] y;
  } ent_t;

  ent_t        mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  ent_t        head;
  logic        full;
  logic        empty;
  logic        room;
  logic        drop;
  logic        push;
  logic        pop;
  logic        issue;
  logic        dec;

  // Extra MSB tells a full ring from an empty one.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head  = mem[rptr[AW-1:0]];
  assign room  = (inflight < 5'(MAX_INFLIGHT));

`ifdef CORDIC_RANGE_CHECK_EN
  // 17-bit magnitude so that -32768 maps to +32768.
  function automatic logic [16:0] mag(input logic [15:0] v);
    mag = v[15] ? (17'd0 - {1'b1, v}) : {1'b0, v};
  endfunction

  assign drop = !empty && !head.mode &&
                (mag(head.y) >= mag(head.x));
`else
  assign drop = 1'b0;
`endif

  // A dropped entry never reaches the core, so it needs no credit.
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign pop      = !empty && (room || drop);
  assign issue    = pop && !drop;
  assign dec      = done && (inflight != 5'd0);
  assign busy     = !empty || (inflight != 5'd0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr[AW-1:0]] <= '{in_mode, in_x, in_y};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      en       <= 1'b0;
      a        <= '0;
      b        <= '0;
      c        <= '0;
      inflight <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      en <= issue;
      if (issue) begin
        a <= head.x;
        b <= head.mode ? 16'd0 : head.y;
        c <= head.mode ? head.y : 16'd0;
      end
      inflight <= inflight + 5'(issue) - 5'(dec);
    end
  end

`ifdef CORDIC_RANGE_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) range_err <= 1'b0;
    else        range_err <= drop;
  end
`else
  assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_line_issue.sv
// Scoreboard bench for cordic_line_issue (DEPTH=4, MAX_INFLIGHT=2).
// Directed vectors; a negedge monitor checks every en cycle against a queue.
module tb_cordic_line_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_mode;
  logic [15:0] in_x;
  logic [15:0] in_y;
  logic        en;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] c;
  logic        done;
  logic [4:0]  inflight;
  logic        busy;
  logic        range_err;

  int n_chk  = 0;
  int n_fail = 0;
  int en_cnt = 0;
  int rng_cnt = 0;
  int exp_rng = 0;
  logic [47:0] exp_q[$];

  always #5 clk = ~clk;

  cordic_line_issue #(.DEPTH(4), .MAX_INFLIGHT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_x(in_x), .in_y(in_y),
    .en(en), .a(a), .b(b), .c(c),
    .done(done), .inflight(inflight),
    .busy(busy), .range_err(range_err)
  );

  task automatic check(input string nm,
                       input logic [47:0] act,
                       input logic [47:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [16:0] mg(input logic [15:0] v);
    return v[15] ? 17'(32'sd0 - 32'(signed'(v))) : {1'b0, v};
  endfunction

  function automatic logic drops(input logic m,
                                 input logic [15:0] x,
                                 input logic [15:0] y);
`ifdef CORDIC_RANGE_CHECK_EN
    return !m && (mg(y) >= mg(x));
`else
    return 1'b0;
`endif
  endfunction

  task automatic expect_entry(input logic m,
                              input logic [15:0] x,
                              input logic [15:0] y);
    if (drops(m, x, y)) exp_rng++;
    else if (m) exp_q.push_back({x, 16'd0, y});
    else exp_q.push_back({x, y, 16'd0});
  endtask

  task automatic push(input logic m,
                      input logic [15:0] x,
                      input logic [15:0] y);
    logic ok;
    int   n;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 50) begin
      in_valid = 1'b1;
      in_mode  = m;
      in_x     = x;
      in_y     = y;
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (ok) expect_entry(m, x, y);
    else check("push_timeout", 48'd0, 48'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    done = 1'b1;
    while (busy && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    done = 1'b0;
    check("drain_idle", 48'(busy), 48'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (range_err) rng_cnt++;
      if (en) begin
        en_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_en", 48'd1, 48'd0);
        end else begin
          check("issue_abc", {a, b, c}, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    int k;
    int cyc;
    logic ok;
    logic [15:0] fx [6];
    logic [15:0] fy [6];

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_mode = 1'b0;
    in_x = '0;
    in_y = '0;
    done = 1'b0;
    #12;
    check("rst_en", 48'(en), 48'd0);
    check("rst_abc", {a, b, c}, 48'd0);
    check("rst_inflight", 48'(inflight), 48'd0);
    check("rst_busy", 48'(busy), 48'd0);
    check("rst_ready", 48'(in_ready), 48'd1);
    check("rst_range", 48'(range_err), 48'd0);
    #11;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single divide
    push(1'b0, 16'd26213, 16'd19660);
    check("div_en_wait", 48'(en), 48'd0);
    check("div_busy", 48'(busy), 48'd1);
    @(posedge clk);
    #1;
    check("div_en", 48'(en), 48'd1);
    check("div_abc", {a, b, c},
          {16'd26213, 16'd19660, 16'd0});
    check("div_inflight", 48'(inflight), 48'd1);
    done = 1'b1;
    @(posedge clk);
    #1;
    done = 1'b0;
    check("div_done_if", 48'(inflight), 48'd0);
    check("div_done_busy", 48'(busy), 48'd0);
    check("div_en_drop", 48'(en), 48'd0);

    // burst of multiplies with done held high
    base = en_cnt;
    done = 1'b1;
    push(1'b1, 16'd26213, 16'd19660);
    push(1'b1, 16'd26213, 16'd3276);
    push(1'b1, 16'd26213, 16'd10485);
    push(1'b1, 16'd26213, 16'd6553);
    @(posedge clk);
    #1;
    check("burst_last_en", 48'(en), 48'd1);
    @(posedge clk);
    #1;
    done = 1'b0;
    check("burst_inflight", 48'(inflight), 48'd0);
    check("burst_count", 48'(en_cnt - base), 48'd4);

    // throttle at MAX_INFLIGHT=2
    base = en_cnt;
    push(1'b0, 16'd20000, 16'd100);
    push(1'b0, 16'd20000, 16'd200);
    push(1'b0, 16'd20000, 16'd300);
    push(1'b0, 16'd20000, 16'd400);
    check("thr_inflight", 48'(inflight), 48'd2);
    check("thr_ready", 48'(in_ready), 48'd1);
    repeat (3) @(posedge clk);
    #1;
    check("thr_stall_cnt", 48'(en_cnt - base), 48'd2);
    check("thr_stall_en", 48'(en), 48'd0);
    done = 1'b1;
    @(posedge clk);
    #1;
    done = 1'b0;
    check("thr_dec", 48'(inflight), 48'd1);
    check("thr_dec_en", 48'(en), 48'd0);
    @(posedge clk);
    #1;
    check("thr_resume_en", 48'(en), 48'd1);
    check("thr_resume_if", 48'(inflight), 48'd2);
    repeat (3) @(posedge clk);
    #1;
    check("thr_one_more", 48'(en_cnt - base), 48'd3);
    drain();

    // full FIFO with issue stalled
    push(1'b1, 16'd1000, 16'd11);
    push(1'b1, 16'd1000, 16'd22);
    repeat (2) @(posedge clk);
    #1;
    check("full_pre_if", 48'(inflight), 48'd2);
    for (int i = 0; i < 6; i++) begin
      fx[i] = 16'(16'd500 + 16'(i));
      fy[i] = 16'(16'd40 + 16'(i));
    end
    k = 0;
    cyc = 0;
    while (k < 6 && cyc < 60) begin
      in_valid = 1'b1;
      in_mode  = 1'b1;
      in_x     = fx[k];
      in_y     = fy[k];
      ok = in_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (ok) begin
        expect_entry(1'b1, fx[k], fy[k]);
        k++;
      end
      if (cyc == 6) begin
        check("full_accepts", 48'(k), 48'd4);
        check("full_ready", 48'(in_ready), 48'd0);
      end
      if (cyc >= 8) done = 1'b1;
    end
    in_valid = 1'b0;
    check("full_all_in", 48'(k), 48'd6);
    drain();

    // range check boundaries
    done = 1'b1;
    push(1'b0, 16'd16384, 16'd19660);
    push(1'b0, 16'd26213, 16'd8192);
    push(1'b0, 16'h8000, 16'hC000);
    push(1'b0, 16'd16384, 16'h8000);
    push(1'b0, 16'd8192, 16'hE000);
    push(1'b1, 16'd100, 16'd30000);
    drain();
    repeat (2) @(posedge clk);
    #1;
    check("range_pulses", 48'(rng_cnt), 48'(exp_rng));

    // reset mid-burst: 3 queued, 2 in flight
    for (int i = 0; i < 5; i++) begin
      push(1'b0, 16'd30000, 16'(16'd7 + 16'(i)));
    end
    repeat (2) @(posedge clk);
    #1;
    check("mid_inflight", 48'(inflight), 48'd2);
    check("mid_queue", 48'(exp_q.size()), 48'd3);
    base = en_cnt;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_en", 48'(en), 48'd0);
    check("mid_rst_abc", {a, b, c}, 48'd0);
    check("mid_rst_if", 48'(inflight), 48'd0);
    check("mid_rst_busy", 48'(busy), 48'd0);
    check("mid_rst_ready", 48'(in_ready), 48'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    done = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    done = 1'b0;
    check("post_rst_if", 48'(inflight), 48'd0);
    check("post_rst_busy", 48'(busy), 48'd0);
    check("post_rst_noen", 48'(en_cnt - base), 48'd0);

    push(1'b1, 16'd1234, 16'd4321);
    @(posedge clk);
    #1;
    check("post_rst_issue", 48'(en), 48'd1);
    drain();
    repeat (2) @(posedge clk);
    #1;
    check("sb_empty", 48'(exp_q.size()), 48'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
